ir_err_compute: RTL and testbench

//  Producer side of the err_sat/err_vld interface consumed by the P/I/D term blocks.

---
 rtl/ir_err_compute.sv | 106 ++++++++++
 tb/tb_ir_err_compute.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ir_err_compute.sv
// IR line-sensor heading error: accumulates an 8-sample frame with signed
// power-of-two weights, then scales and saturates it into a 10-bit error.
module ir_err_compute #(
  parameter int SAMPLE_W = 12,
  parameter int ERR_W    = 10,
  parameter int SHIFT    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_start,
  input  logic                sample_vld,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                busy,
  output logic [ERR_W-1:0]    err_sat,
  output logic                err_vld
);

  localparam int ACC_W = SAMPLE_W + 5;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (ERR_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(2 ** (ERR_W - 1));

  // Handshake: a sample is consumed on any rising edge where sample_vld is
  // high and the block is in ACCUM (or frame_start is high in the same cycle).
  // err_vld is a single-cycle strobe; there is no back-pressure.
  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

  state_t                  state;
  logic [2:0]              ch_cnt;
  logic signed [ACC_W-1:0] acc;

  logic [2:0]              ch_sel;
  logic [ACC_W-1:0]        samp_z;
  logic signed [ACC_W-1:0] term_v;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] shifted;
  logic [ERR_W-1:0]        sat_val;

  // ch0..ch7 weights -8,-4,-2,-1,+1,+2,+4,+8 built from shifts only
  always_comb begin
    ch_sel = frame_start ? 3'd0 : ch_cnt;
    samp_z = {{(ACC_W-SAMPLE_W){1'b0}}, sample};
    term_v = '0;
    case (ch_sel)
      3'd0: term_v = -$signed(samp_z << 3);
      3'd1: term_v = -$signed(samp_z << 2);
      3'd2: term_v = -$signed(samp_z << 1);
      3'd3: term_v = -$signed(samp_z);
      3'd4: term_v = $signed(samp_z);
      3'd5: term_v = $signed(samp_z << 1);
      3'd6: term_v = $signed(samp_z << 2);
      default: term_v = $signed(samp_z << 3);
    endcase
    acc_next = acc + term_v;
    shifted  = acc_next >>> SHIFT;
    if (shifted > SAT_MAX)      sat_val = SAT_MAX[ERR_W-1:0];
    else if (shifted < SAT_MIN) sat_val = SAT_MIN[ERR_W-1:0];
    else                        sat_val = shifted[ERR_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ch_cnt  <= '0;
      acc     <= '0;
      err_sat <= '0;
      err_vld <= 1'b0;
      busy    <= 1'b0;
    end else begin
      err_vld <= 1'b0;
      if (frame_start) begin
        // restart from any state; beats completing the current frame
        state  <= ACCUM;
        busy   <= 1'b1;
        acc    <= sample_vld ? term_v : '0;
        ch_cnt <= sample_vld ? 3'd1 : 3'd0;
      end else begin
        case (state)
          ACCUM: begin
            if (sample_vld) begin
              acc <= acc_next;
              if (ch_cnt == 3'd7) begin
                // err_sat and err_vld land together in the OUT cycle
                state   <= OUT;
                busy    <= 1'b0;
                ch_cnt  <= '0;
                err_sat <= sat_val;
                err_vld <= 1'b1;
              end else begin
                ch_cnt <= ch_cnt + 3'd1;
              end
            end
          end
          OUT: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ir_err_compute.sv
// Randomized bench for ir_err_compute: frames checked against a weighted-sum
// model, plus directed reset, restart, clamp and idle-noise scenarios.
module tb_ir_err_compute;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic        sample_vld;
  logic [11:0] sample;
  logic        busy;
  logic [9:0]  err_sat;
  logic        err_vld;

  int checks   = 0;
  int failures = 0;
  int vld_seen = 0;
  int vld_exp  = 0;

  logic [9:0]  exp_q[$];
  logic [9:0]  last_exp;
  logic [11:0] frm[8];
  int          wts[8];

  ir_err_compute dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .sample_vld(sample_vld),
    .sample(sample), .busy(busy), .err_sat(err_sat), .err_vld(err_vld)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", tag, got, exp);
    end
  endtask

  // Reference: floor(sum(w*s)/8), clamped to the 10-bit signed range
  function automatic logic [9:0] model();
    int sum = 0;
    int sh;
    for (int i = 0; i < 8; i++) sum += wts[i] * int'(frm[i]);
    sh = sum >>> 3;
    if (sh > 511)  sh = 511;
    if (sh < -512) sh = -512;
    return sh[9:0];
  endfunction

  // Scoreboard: every strobe must match the oldest expected frame result
  always @(negedge clk) begin
    if (rst_n && err_vld) begin
      vld_seen++;
      if (exp_q.size() == 0) check("unexpected_vld", 32'd1, 32'd0);
      else check("err_sat", {22'b0, err_sat}, {22'b0, exp_q.pop_front()});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    frame_start = 1'b0;
    sample_vld  = 1'b0;
    sample      = 12'($urandom_range(0, 4095));
  endtask

  // Send samples first..last of frm, each preceded by up to gap_max idle cycles
  task automatic send_samples(input int first, input int last, input int gap_max);
    for (int i = first; i <= last; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        idle_inputs();
        step();
      end
      sample_vld = 1'b1;
      sample     = frm[i];
      step();
      idle_inputs();
    end
  endtask

  // Full frame; with b2b the caller starts the next frame during the OUT cycle
  task automatic send_frame(input int gap_max, input bit coincident, input bit b2b);
    last_exp = model();
    exp_q.push_back(last_exp);
    vld_exp++;
    frame_start = 1'b1;
    sample_vld  = coincident;
    sample      = frm[0];
    step();
    idle_inputs();
    check("busy_in_frame", {31'b0, busy}, 32'd1);
    send_samples(coincident ? 1 : 0, 7, gap_max);
    check("vld_latency", {31'b0, err_vld}, 32'd1);
    check("busy_in_out", {31'b0, busy}, 32'd0);
    if (!b2b) begin
      step();
      check("vld_one_cycle", {31'b0, err_vld}, 32'd0);
    end
  endtask

  task automatic set_frame(input logic [11:0] v0, input logic [11:0] v1,
                           input logic [11:0] v2, input logic [11:0] v3,
                           input logic [11:0] v4, input logic [11:0] v5,
                           input logic [11:0] v6, input logic [11:0] v7);
    frm[0] = v0; frm[1] = v1; frm[2] = v2; frm[3] = v3;
    frm[4] = v4; frm[5] = v5; frm[6] = v6; frm[7] = v7;
  endtask

  initial begin
    wts = '{-8, -4, -2, -1, 1, 2, 4, 8};
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check("reset_err_sat", {22'b0, err_sat}, 32'd0);
    check("reset_err_vld", {31'b0, err_vld}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // balanced frame, coincident first sample
    set_frame(12'h100, 12'h100, 12'h100, 12'h100, 12'h100, 12'h100, 12'h100, 12'h100);
    send_frame(0, 1'b1, 1'b0);
    // ch7 only, 2-cycle gaps
    set_frame(0, 0, 0, 0, 0, 0, 0, 12'h010);
    last_exp = model();
    exp_q.push_back(last_exp);
    vld_exp++;
    frame_start = 1'b1;
    step();
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      repeat (2) step();
      sample_vld = 1'b1;
      sample     = frm[i];
      step();
      idle_inputs();
    end
    check("gap_vld_latency", {31'b0, err_vld}, 32'd1);
    step();
    check("gap_vld_one_cycle", {31'b0, err_vld}, 32'd0);
    check("gap_err_sat_held", {22'b0, err_sat}, 32'h010);

    // clamps
    set_frame(12'hFFF, 0, 0, 0, 0, 0, 0, 0);
    send_frame(1, 1'b0, 1'b0);
    check("neg_clamp", {22'b0, err_sat}, 32'h200);
    set_frame(0, 0, 0, 0, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
    send_frame(1, 1'b1, 1'b0);
    check("pos_clamp", {22'b0, err_sat}, 32'h1FF);

    // restart after 3 samples: only the second frame may produce a strobe
    set_frame(12'hFFF, 12'hFFF, 12'hFFF, 0, 0, 0, 0, 0);
    frame_start = 1'b1;
    step();
    idle_inputs();
    send_samples(0, 2, 1);
    set_frame(0, 0, 0, 0, 0, 0, 12'h008, 0);
    send_frame(1, 1'b0, 1'b0);
    check("restart_err_sat", {22'b0, err_sat}, 32'h004);

    // random frames, some back-to-back through OUT
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 8; i++)
        frm[i] = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom_range(0, 4095));
      send_frame(2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
    end
    idle_inputs();
    step();
    step();

    // idle sample noise must not produce a strobe or change err_sat
    for (int i = 0; i < 12; i++) begin
      sample_vld = 1'($urandom_range(0, 1));
      sample     = 12'($urandom_range(0, 4095));
      step();
    end
    idle_inputs();
    step();
    check("idle_err_sat_held", {22'b0, err_sat}, {22'b0, last_exp});

    // reset after ch5, asserted between edges
    for (int i = 0; i < 8; i++) frm[i] = 12'($urandom_range(0, 4095));
    frame_start = 1'b1;
    step();
    idle_inputs();
    send_samples(0, 5, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_err_sat", {22'b0, err_sat}, 32'd0);
    check("midreset_busy", {31'b0, busy}, 32'd0);
    check("midreset_err_vld", {31'b0, err_vld}, 32'd0);
    step();
    rst_n = 1'b1;
    sample_vld = 1'b1;
    step();
    step();
    idle_inputs();
    step();
    check("post_reset_err_sat", {22'b0, err_sat}, 32'd0);
    check("strobe_count", vld_seen, vld_exp);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
